// File: rtl/cpu_types_pkg.sv
// Shared CPU types: RAM handshake state, word type and memory arbiter FSM states.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DGRANT = 2'd1,
    IGRANT = 2'd2
  } arb_state_t;

endpackage

// File: rtl/arb_stall_counter.sv
// Saturating cycle counter used for arbiter stall statistics (ARB_STALL_CNT_EN builds only).
module arb_stall_counter #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: step while enabled, stick at all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register with synchronous clear
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the unified single-ported RAM between instruction fetch and data access.
// Optional stall counters are built when ARB_STALL_CNT_EN is defined.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int DSTREAK_MAX = 4,
  parameter int CNT_W       = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        arb_err
`ifdef ARB_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0] istall_cnt,
  output logic [CNT_W-1:0] dstall_cnt
`endif
);

  localparam int SW = $clog2(DSTREAK_MAX + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(DSTREAK_MAX);

  arb_state_t  state_q, state_d;
  logic        ramren_q, ramren_d;
  logic        ramwen_q, ramwen_d;
  word_t       ramaddr_q, ramaddr_d;
  word_t       ramstore_q, ramstore_d;
  logic        arb_err_q, arb_err_d;
  logic [SW-1:0] streak_q, streak_d;

  ramstate_t   rs_s;
  logic        d_pend_s;
  logic        d_done_s;
  logic        i_done_s;

  assign rs_s     = ramstate_t'(ramstate);
  assign d_pend_s = dREN | dWEN;
  assign d_done_s = (state_q == DGRANT) && (rs_s == ACCESS);
  assign i_done_s = (state_q == IGRANT) && (rs_s == ACCESS);

  // Grant decision, transaction sequencing and RAM-side next values
  always_comb begin
    state_d    = state_q;
    ramren_d   = ramren_q;
    ramwen_d   = ramwen_q;
    ramaddr_d  = ramaddr_q;
    ramstore_d = ramstore_q;
    arb_err_d  = 1'b0;
    case (state_q)
      IDLE: begin
        // Data wins unless fetch has waited through a full data streak
        if (d_pend_s && (!iREN || (streak_q < STREAK_MAX))) begin
          state_d    = DGRANT;
          ramwen_d   = dWEN;
          ramren_d   = dREN & ~dWEN;
          ramaddr_d  = daddr;
          ramstore_d = dstore;
        end else if (iREN) begin
          state_d   = IGRANT;
          ramren_d  = 1'b1;
          ramwen_d  = 1'b0;
          ramaddr_d = iaddr;
        end else begin
          state_d  = IDLE;
          ramren_d = 1'b0;
          ramwen_d = 1'b0;
        end
      end
      DGRANT, IGRANT: begin
        if (rs_s == ACCESS) begin
          state_d  = IDLE;
          ramren_d = 1'b0;
          ramwen_d = 1'b0;
        end else if (rs_s == ERROR) begin
          state_d   = IDLE;
          ramren_d  = 1'b0;
          ramwen_d  = 1'b0;
          arb_err_d = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d  = IDLE;
        ramren_d = 1'b0;
        ramwen_d = 1'b0;
      end
    endcase
  end

  // Starvation guard: consecutive data completions seen while fetch is waiting
  always_comb begin
    streak_d = streak_q;
    if (!iREN) begin
      streak_d = {SW{1'b0}};
    end else if (i_done_s) begin
      streak_d = {SW{1'b0}};
    end else if (d_done_s && (streak_q < STREAK_MAX)) begin
      streak_d = streak_q + {{(SW-1){1'b0}}, 1'b1};
    end else begin
      streak_d = streak_q;
    end
  end

  // FSM state and registered RAM-side outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      ramren_q   <= 1'b0;
      ramwen_q   <= 1'b0;
      ramaddr_q  <= 32'h0000_0000;
      ramstore_q <= 32'h0000_0000;
      arb_err_q  <= 1'b0;
      streak_q   <= {SW{1'b0}};
    end else begin
      state_q    <= state_d;
      ramren_q   <= ramren_d;
      ramwen_q   <= ramwen_d;
      ramaddr_q  <= ramaddr_d;
      ramstore_q <= ramstore_d;
      arb_err_q  <= arb_err_d;
      streak_q   <= streak_d;
    end
  end

  assign ramREN   = ramren_q;
  assign ramWEN   = ramwen_q;
  assign ramaddr  = ramaddr_q;
  assign ramstore = ramstore_q;
  assign arb_err  = arb_err_q;

  // A completion coinciding with reset is not reported to the requester
  assign dwait = ~(d_done_s & ~RST);
  assign iwait = ~(i_done_s & ~RST);
  assign dload = ramload;
  assign iload = ramload;

`ifdef ARB_STALL_CNT_EN
  arb_stall_counter #(.CNT_W(CNT_W)) u_istall (
    .CLK (CLK),
    .RST (RST),
    .inc (iREN & iwait),
    .cnt (istall_cnt)
  );

  arb_stall_counter #(.CNT_W(CNT_W)) u_dstall (
    .CLK (CLK),
    .RST (RST),
    .inc (d_pend_s & dwait),
    .cnt (dstall_cnt)
  );
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scoreboard bench for mem_arbiter; the RAM side is scripted by the bench.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic        iwait, dwait, ramREN, ramWEN, arb_err;
  logic [31:0] iload, dload, ramaddr, ramstore;
`ifdef ARB_STALL_CNT_EN
  logic [15:0] istall_cnt, dstall_cnt;
`endif

  typedef struct packed {
    logic        is_d;
    logic        is_w;
    logic [31:0] addr;
    logic [31:0] store;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc_n, gnt_n;

  mem_arbiter #(.DSTREAK_MAX(4), .CNT_W(16)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .arb_err(arb_err)
`ifdef ARB_STALL_CNT_EN
    , .istall_cnt(istall_cnt), .dstall_cnt(dstall_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Steps until the DUT enables the RAM; idle cycles see FREE
  task automatic wait_grant(input string tag);
    int n;
    n = 0;
    step();
    while (!(ramREN || ramWEN) && n < 20) begin
      ramstate = FREE;
      step();
      n++;
    end
    if (!(ramREN || ramWEN)) chk({tag, "_grant_timeout"}, 32'd0, 32'd1);
  endtask

  // Serves the scoreboard head: nbusy BUSY cycles, then ACCESS with the expected data
  task automatic serve(input string tag, input int nbusy, output int cycles, output int gcycles);
    exp_t e;
    int   b;
    bit   done;
    b = nbusy; done = 1'b0; cycles = 0; gcycles = 0;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb[0];
    while (!done && cycles < 40) begin
      step();
      cycles++;
      if (ramREN || ramWEN) begin
        gcycles++;
        if (b > 0) begin
          ramstate = BUSY;
          b--;
        end else begin
          ramstate = ACCESS;
          ramload  = e.data;
        end
        #1;
        chk({tag, "_ramaddr"}, ramaddr, e.addr);
        chk({tag, "_ramwen"}, {31'd0, ramWEN}, {31'd0, e.is_w});
        chk({tag, "_ramren"}, {31'd0, ramREN}, {31'd0, ~e.is_w});
        if (e.is_w) chk({tag, "_ramstore"}, ramstore, e.store);
        if (ramstate == ACCESS) begin
          done = 1'b1;
          void'(sb.pop_front());
          chk({tag, "_served_wait"}, {31'd0, (e.is_d ? dwait : iwait)}, 32'd0);
          chk({tag, "_other_wait"},  {31'd0, (e.is_d ? iwait : dwait)}, 32'd1);
          chk({tag, "_load"}, (e.is_d ? dload : iload), e.data);
        end else begin
          chk({tag, "_hold_waits"}, {30'd0, iwait, dwait}, 32'd3);
        end
      end else begin
        ramstate = FREE;
        #1;
        chk({tag, "_idle_waits"}, {30'd0, iwait, dwait}, 32'd3);
      end
    end
    if (!done) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    RST = 1'b1; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    iaddr = 32'd0; daddr = 32'd0; dstore = 32'd0; ramload = 32'd0; ramstate = FREE;
    repeat (3) @(posedge CLK);
    #2;
    chk("rst_ramren", {31'd0, ramREN}, 32'd0);
    chk("rst_ramwen", {31'd0, ramWEN}, 32'd0);
    chk("rst_ramaddr", ramaddr, 32'd0);
    chk("rst_ramstore", ramstore, 32'd0);
    chk("rst_waits", {30'd0, iwait, dwait}, 32'd3);
    chk("rst_arb_err", {31'd0, arb_err}, 32'd0);

    // 1: single fetch, ACCESS on the first grant cycle
    RST = 1'b0; iREN = 1'b1; iaddr = 32'h40;
    sb.push_back('{1'b0, 1'b0, 32'h40, 32'h0, 32'h2108000A});
    serve("t1", 0, cyc_n, gnt_n);
    chk("t1_latency", cyc_n, 32'd1);
    iREN = 1'b0;

    // 2: both pending -> data first, then fetch
    iREN = 1'b1; iaddr = 32'h44; dREN = 1'b1; daddr = 32'h100;
    sb.push_back('{1'b1, 1'b0, 32'h100, 32'h0, 32'hA5A50001});
    sb.push_back('{1'b0, 1'b0, 32'h44, 32'h0, 32'h00001111});
    serve("t2_d", 0, cyc_n, gnt_n);
    dREN = 1'b0;
    serve("t2_i", 0, cyc_n, gnt_n);
    iREN = 1'b0;

    // 3: streak guard -> 4 data, 1 fetch, 2 data, then fetch once data stops
    iREN = 1'b1; iaddr = 32'h48; dREN = 1'b1; daddr = 32'h180;
    for (int k = 0; k < 8; k++) begin
      logic is_d;
      is_d = !(k == 4 || k == 7);
      sb.push_back('{is_d, 1'b0, (is_d ? 32'h180 : 32'h48), 32'h0, 32'h10000000 + k});
    end
    for (int k = 0; k < 8; k++) begin
      serve($sformatf("t3_%0d", k), 0, cyc_n, gnt_n);
      if (k == 6) dREN = 1'b0;
    end
    iREN = 1'b0;

    // 4: write held across 3 BUSY cycles
    dWEN = 1'b1; daddr = 32'h200; dstore = 32'hDEADBEEF;
    sb.push_back('{1'b1, 1'b1, 32'h200, 32'hDEADBEEF, 32'h0BADF00D});
    serve("t4", 3, cyc_n, gnt_n);
    chk("t4_grant_cycles", gnt_n, 32'd4);
    dWEN = 1'b0;

    // 5: ERROR on a fetch, then retry
    iREN = 1'b1; iaddr = 32'h80;
    sb.push_back('{1'b0, 1'b0, 32'h80, 32'h0, 32'h5555AAAA});
    wait_grant("t5");
    chk("t5_ramaddr", ramaddr, 32'h80);
    ramstate = ERROR;
    #1;
    chk("t5_err_iwait", {31'd0, iwait}, 32'd1);
    step();
    chk("t5_arb_err", {31'd0, arb_err}, 32'd1);
    chk("t5_idle_ramren", {31'd0, ramREN}, 32'd0);
    chk("t5_idle_iwait", {31'd0, iwait}, 32'd1);
    ramstate = FREE;
    serve("t5_retry", 0, cyc_n, gnt_n);
    chk("t5_arb_err_pulse", {31'd0, arb_err}, 32'd0);
    iREN = 1'b0;

    // 6: reset during a BUSY write
    dWEN = 1'b1; daddr = 32'h300; dstore = 32'h12345678;
    wait_grant("t6");
    chk("t6_ramwen", {31'd0, ramWEN}, 32'd1);
    ramstate = BUSY;
    #1;
    chk("t6_busy_dwait", {31'd0, dwait}, 32'd1);
    step();
    chk("t6_hold_ramwen", {31'd0, ramWEN}, 32'd1);
`ifdef ARB_STALL_CNT_EN
    chk("t6_dstall_nz", {31'd0, (dstall_cnt != 16'd0)}, 32'd1);
`endif
    RST = 1'b1;
    step();
    chk("t6_rst_ramwen", {31'd0, ramWEN}, 32'd0);
    chk("t6_rst_ramren", {31'd0, ramREN}, 32'd0);
    chk("t6_rst_dwait", {31'd0, dwait}, 32'd1);
    chk("t6_rst_ramaddr", ramaddr, 32'd0);
`ifdef ARB_STALL_CNT_EN
    chk("t6_dstall_clr", {16'd0, dstall_cnt}, 32'd0);
`endif
    RST = 1'b0; dWEN = 1'b0; ramstate = FREE;
    step();
    chk("t6_after_waits", {30'd0, iwait, dwait}, 32'd3);
    chk("t6_after_ramwen", {31'd0, ramWEN}, 32'd0);
    chk("sb_drained", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
